// File: rtl/lsu_pkg.sv
// Shared width codes, request bundle and FSM encoding for the load/store unit.
// Misalignment trapping is selected in load_store_unit via LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic req_bad(
        input lsu_req_t r,
        input logic     trap
    );
        logic code_bad;
        logic mis;
        mis = 1'b0;
        case (r.funct3)
            F3_H, F3_HU: mis = r.addr[0];
            F3_W:        mis = |r.addr[1:0];
            default:     mis = 1'b0;
        endcase
        if (r.we)
            code_bad = !(r.funct3 inside {F3_B, F3_H, F3_W});
        else
            code_bad = r.funct3 inside {3'b011, 3'b110, 3'b111};
        return code_bad | (trap & mis);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and store lane merge
// into the word read back from the data RAM.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rword[7:0];
        unique case (offset)
            2'd0: lane_b = rword[7:0];
            2'd1: lane_b = rword[15:8];
            2'd2: lane_b = rword[23:16];
            2'd3: lane_b = rword[31:24];
        endcase
        // Halfword lane follows addr[1] only; addr[0] is dropped here.
        lane_h = offset[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        load_data = rword;
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = rword;
        endcase
    end

    always_comb begin
        merged = rword;
        if (funct3 == F3_B) begin
            unique case (offset)
                2'd0: merged[7:0]   = wdata[7:0];
                2'd1: merged[15:8]  = wdata[7:0];
                2'd2: merged[23:16] = wdata[7:0];
                2'd3: merged[31:24] = wdata[7:0];
            endcase
        end else if (funct3 == F3_H) begin
            if (offset[1])
                merged[31:16] = wdata[15:0];
            else
                merged[15:0] = wdata[15:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: IDLE/ACCESS/MERGE/RESP over a word RAM.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    lsu_state_e  state;
    lsu_state_e  state_nx;
    lsu_req_t    req_in;
    lsu_req_t    req_q;
    logic [31:0] merge_q;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        accept;
    logic        bad;
    logic        is_ld;
    logic        is_sw;
    logic        is_part;

    assign req_in   = {req_we, req_funct3, req_addr, req_wdata};
    assign accept   = req_valid && (state == IDLE);
    assign bad      = req_bad(req_in, TRAP);
    assign mem_addr = {req_q.addr[31:2], 2'b00};

    assign is_ld   = !req_q.we;
    assign is_sw   = req_q.we && (req_q.funct3 == F3_W);
    assign is_part = req_q.we && (req_q.funct3 != F3_W);

    lsu_align u_align (
        .funct3    (req_q.funct3),
        .offset    (req_q.addr[1:0]),
        .rword     (mem_dout),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_din    = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = bad ? RESP : ACCESS;
            end
            ACCESS: begin
                unique case (1'b1)
                    is_ld:   state_nx = RESP;
                    is_sw: begin
                        mem_we   = 1'b1;
                        mem_din  = req_q.wdata;
                        state_nx = RESP;
                    end
                    is_part: state_nx = MERGE;
                endcase
            end
            MERGE: begin
                mem_we   = 1'b1;
                mem_din  = merge_q;
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Response registers only change on the edge that enters RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= '0;
            merge_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= req_in;
                if (bad) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                end
            end
            if (state == ACCESS) begin
                merge_q <= merged;
                if (state_nx == RESP) begin
                    resp_err   <= 1'b0;
                    resp_rdata <= req_q.we ? 32'h0 : load_data;
                end
            end
            if (state == MERGE) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

endmodule
